// File: rtl/jt51_slotreg.sv
// jt51_slotreg
// Time-multiplexed operator/channel register file for the FM core.
// A slot counter visits every {op,ch} slot once per sample. The operator
// register of the current slot and the channel register of its channel are
// presented in step with the counter. Host writes are masked
// read-modify-write operations held pending until the target slot comes round.
//
// Optional feature: define JT51_SLOTREG_RDBK_EN to build the readback port.
// Without it, rd_data/rd_valid are tied to zero and the rd_* inputs are unused.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cen                  slot-advance enable
//   wr_req/sel/op/ch     write request (level) and target; sel=1 -> channel reg
//   wr_mask, wr_data     per-bit enable and data, LSB-aligned
//   busy, wr_ack         write pending / one-clk commit pulse
//   rd_req/sel/op/ch     readback request and target (same encoding as write)
//   rd_data, rd_valid    readback value (zero-extended) and one-clk strobe
//   cur_slot, cur_op     slot currently presented and its operator field
//   zero                 high while cur_slot == 0
//   op_dout, ch_dout     operator / channel register of the current slot
//
// Handshake: a request is taken in any clk where *_req is high and no request
// of the same kind is pending; requests arriving while one is pending are
// dropped (no queueing, no ack). Completion is signalled by a one-clk pulse.
module jt51_slotreg #(
  parameter int CH  = 8,
  parameter int OPS = 4,
  parameter int OPW = 42,
  parameter int CHW = 26,
  localparam int SLOTS = CH * OPS,
  localparam int SW    = $clog2(SLOTS),
  localparam int CW    = $clog2(CH),
  localparam int OW    = (OPS > 1) ? $clog2(OPS) : 1,
  localparam int DW    = (OPW > CHW) ? OPW : CHW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wr_req,
  input  logic          wr_sel,
  input  logic [OW-1:0] wr_op,
  input  logic [CW-1:0] wr_ch,
  input  logic [DW-1:0] wr_mask,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic          rd_sel,
  input  logic [OW-1:0] rd_op,
  input  logic [CW-1:0] rd_ch,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [SW-1:0] cur_slot,
  output logic [OW-1:0] cur_op,
  output logic          zero,
  output logic [OPW-1:0] op_dout,
  output logic [CHW-1:0] ch_dout
);

  // Storage (not reset)
  logic [OPW-1:0] op_mem [SLOTS];
  logic [CHW-1:0] ch_mem [CH];

  // Slot counter and presented data
  logic [SW-1:0]  cur_slot_q, cur_slot_d, next_slot;
  logic           zero_q, zero_d;
  logic [OPW-1:0] op_dout_q, op_dout_d;
  logic [CHW-1:0] ch_dout_q, ch_dout_d;
  logic [CW-1:0]  cur_ch;

  // Pending write
  logic           busy_q, busy_d;
  logic           wr_sel_q, wr_sel_d;
  logic [OW-1:0]  wr_op_q, wr_op_d;
  logic [CW-1:0]  wr_ch_q, wr_ch_d;
  logic [DW-1:0]  wr_mask_q, wr_mask_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic           wr_ack_q, wr_ack_d;
  logic           wr_hit;
  logic [OPW-1:0] op_wr_val;
  logic [CHW-1:0] ch_wr_val;

  // Op target hits on the exact {op,ch} slot; channel target hits on the
  // first slot whose channel field matches. With OPS=1 the op field is
  // truncated away and the slot index is just the channel.
  function automatic logic slot_hit(input logic          sel,
                                    input logic [OW-1:0] op,
                                    input logic [CW-1:0] ch,
                                    input logic [SW-1:0] slot);
    if (sel) return slot[CW-1:0] == ch;
    else     return slot == SW'({op, ch});
  endfunction

  assign cur_ch = cur_slot_q[CW-1:0];

  always_comb begin
    cur_slot_d = cur_slot_q;
    zero_d     = zero_q;
    op_dout_d  = op_dout_q;
    ch_dout_d  = ch_dout_q;
    busy_d     = busy_q;
    wr_sel_d   = wr_sel_q;
    wr_op_d    = wr_op_q;
    wr_ch_d    = wr_ch_q;
    wr_mask_d  = wr_mask_q;
    wr_data_d  = wr_data_q;

    next_slot = (cur_slot_q == SW'(SLOTS - 1)) ? '0 : cur_slot_q + SW'(1);
    wr_hit    = busy_q && cen && slot_hit(wr_sel_q, wr_op_q, wr_ch_q, cur_slot_q);
    wr_ack_d  = wr_hit;

    // Prefetch the next slot's registers so the outputs line up with
    // cur_slot. The committing slot is never the prefetched one, so a write
    // becomes visible only when its slot comes round again.
    if (cen) begin
      cur_slot_d = next_slot;
      zero_d     = (next_slot == '0);
      op_dout_d  = op_mem[next_slot];
      ch_dout_d  = ch_mem[next_slot[CW-1:0]];
    end

    if (wr_hit) begin
      busy_d = 1'b0;
    end else if (!busy_q && wr_req) begin
      busy_d    = 1'b1;
      wr_sel_d  = wr_sel;
      wr_op_d   = wr_op;
      wr_ch_d   = wr_ch;
      wr_mask_d = wr_mask;
      wr_data_d = wr_data;
    end

    // Masked merge; mask bits above the register width are dropped here.
    op_wr_val = (op_mem[cur_slot_q] & ~wr_mask_q[OPW-1:0])
              | (wr_data_q[OPW-1:0] & wr_mask_q[OPW-1:0]);
    ch_wr_val = (ch_mem[cur_ch] & ~wr_mask_q[CHW-1:0])
              | (wr_data_q[CHW-1:0] & wr_mask_q[CHW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot_q <= '0;
      zero_q     <= 1'b1;
      op_dout_q  <= '0;
      ch_dout_q  <= '0;
      busy_q     <= 1'b0;
      wr_sel_q   <= 1'b0;
      wr_op_q    <= '0;
      wr_ch_q    <= '0;
      wr_mask_q  <= '0;
      wr_data_q  <= '0;
      wr_ack_q   <= 1'b0;
    end else begin
      cur_slot_q <= cur_slot_d;
      zero_q     <= zero_d;
      op_dout_q  <= op_dout_d;
      ch_dout_q  <= ch_dout_d;
      busy_q     <= busy_d;
      wr_sel_q   <= wr_sel_d;
      wr_op_q    <= wr_op_d;
      wr_ch_q    <= wr_ch_d;
      wr_mask_q  <= wr_mask_d;
      wr_data_q  <= wr_data_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  // RAM write port. Reset is async, so a reset mid-pending clears busy_q and
  // the write never reaches this block.
  always_ff @(posedge clk) begin
    if (wr_hit && !wr_sel_q) op_mem[cur_slot_q] <= op_wr_val;
    if (wr_hit &&  wr_sel_q) ch_mem[cur_ch]     <= ch_wr_val;
  end

`ifdef JT51_SLOTREG_RDBK_EN
  logic          rd_busy_q, rd_busy_d;
  logic          rd_sel_q, rd_sel_d;
  logic [OW-1:0] rd_op_q, rd_op_d;
  logic [CW-1:0] rd_ch_q, rd_ch_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_hit;

  always_comb begin
    rd_busy_d  = rd_busy_q;
    rd_sel_d   = rd_sel_q;
    rd_op_d    = rd_op_q;
    rd_ch_d    = rd_ch_q;
    rd_data_d  = rd_data_q;
    rd_hit     = rd_busy_q && cen && slot_hit(rd_sel_q, rd_op_q, rd_ch_q, cur_slot_q);
    rd_valid_d = rd_hit;

    if (rd_hit) begin
      rd_busy_d = 1'b0;
      // RAM is read before the same-clk write lands, so a coincident write
      // to this slot is not seen.
      rd_data_d = rd_sel_q ? DW'(ch_mem[cur_ch]) : DW'(op_mem[cur_slot_q]);
    end else if (!rd_busy_q && rd_req) begin
      rd_busy_d = 1'b1;
      rd_sel_d  = rd_sel;
      rd_op_d   = rd_op;
      rd_ch_d   = rd_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_busy_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_op_q    <= '0;
      rd_ch_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_busy_q  <= rd_busy_d;
      rd_sel_q   <= rd_sel_d;
      rd_op_q    <= rd_op_d;
      rd_ch_q    <= rd_ch_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_req, rd_sel, rd_op, rd_ch};
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
`endif

  assign cur_slot = cur_slot_q;
  assign cur_op   = OW'(cur_slot_q >> CW);
  assign zero     = zero_q;
  assign op_dout  = op_dout_q;
  assign ch_dout  = ch_dout_q;
  assign busy     = busy_q;
  assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_jt51_slotreg.sv
// Testbench for jt51_slotreg (CH=8, OPS=4, OPW=42, CHW=26).
// Stimulus issues writes/reads and pushes expected events into queues; a
// monitor on the falling edge pops and compares whenever the DUT acks, returns
// a read, or presents a slot that has a pending data expectation.
module tb_jt51_slotreg;
  localparam int CH = 8, OPS = 4, OPW = 42, CHW = 26;
  localparam int SLOTS = 32, SW = 5, CW = 3, OW = 2, DW = 42;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          cen, wr_req, wr_sel, rd_req, rd_sel;
  logic [OW-1:0] wr_op, rd_op;
  logic [CW-1:0] wr_ch, rd_ch;
  logic [DW-1:0] wr_mask, wr_data, rd_data;
  logic          busy, wr_ack, rd_valid, zero;
  logic [SW-1:0] cur_slot;
  logic [OW-1:0] cur_op;
  logic [OPW-1:0] op_dout;
  logic [CHW-1:0] ch_dout;

  jt51_slotreg #(.CH(CH), .OPS(OPS), .OPW(OPW), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_op(wr_op), .wr_ch(wr_ch),
    .wr_mask(wr_mask), .wr_data(wr_data), .busy(busy), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_op(rd_op), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .cur_slot(cur_slot), .cur_op(cur_op), .zero(zero),
    .op_dout(op_dout), .ch_dout(ch_dout)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed { logic is_ch; logic [SW-1:0] slot; logic [DW-1:0] val; } dchk_t;
  typedef struct packed { logic [SW-1:0] slot; logic [DW-1:0] val; } rchk_t;
  dchk_t         exp_data_q[$];
  logic [SW-1:0] exp_ack_q[$];
  rchk_t         exp_rd_q[$];

  int total = 0, bad = 0, ack_cnt = 0, rd_cnt = 0;
  logic [SW-1:0] model_slot, prev_slot;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent slot counter model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   model_slot <= '0;
    else if (cen) model_slot <= (model_slot == SW'(SLOTS - 1)) ? '0 : model_slot + SW'(1);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("cur_slot", 64'(cur_slot), 64'(model_slot));
      check("zero", 64'(zero), 64'(model_slot == '0));
      check("cur_op", 64'(cur_op), 64'(model_slot[SW-1:CW]));
      if (wr_ack) begin
        ack_cnt++;
        if (exp_ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got wr_ack=1 at slot %0d expected none", model_slot);
        end else begin
          // wr_ack is registered: it rises in the clk after the commit clk.
          check("ack_commit_slot", 64'(prev_slot), 64'(exp_ack_q.pop_front()));
        end
      end
      if (rd_valid) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd_valid: got rd_valid=1 rd_data=%0h expected none", rd_data);
        end else begin
          rchk_t r;
          r = exp_rd_q.pop_front();
          check("rd_slot", 64'(prev_slot), 64'(r.slot));
          check("rd_data", 64'(rd_data), 64'(r.val));
        end
      end
      for (int i = 0; i < exp_data_q.size(); i++) begin
        if (exp_data_q[i].slot == model_slot) begin
          if (exp_data_q[i].is_ch)
            check("ch_dout", 64'(ch_dout), 64'(exp_data_q[i].val[CHW-1:0]));
          else
            check("op_dout", 64'(op_dout), 64'(exp_data_q[i].val[OPW-1:0]));
          exp_data_q.delete(i);
          break;
        end
      end
      prev_slot = model_slot;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [SW-1:0] ch_commit_slot(input logic [SW-1:0] m, input logic [CW-1:0] ch);
    logic [SW-1:0] s;
    s = m;
    for (int k = 0; k < CH; k++) begin
      if (s[CW-1:0] == ch) return s;
      s = s + SW'(1);
    end
    return s;
  endfunction

  // One-clk write request; returns the slot where the commit is expected.
  task automatic do_write(input logic sel, input logic [OW-1:0] op, input logic [CW-1:0] ch,
                          input logic [DW-1:0] mask, input logic [DW-1:0] data,
                          output logic [SW-1:0] cslot);
    wr_req = 1'b1; wr_sel = sel; wr_op = op; wr_ch = ch; wr_mask = mask; wr_data = data;
    tick();
    wr_req = 1'b0;
    cslot = sel ? ch_commit_slot(model_slot, ch) : {op, ch};
    exp_ack_q.push_back(cslot);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic push_data(input logic is_ch, input logic [SW-1:0] slot, input logic [DW-1:0] val);
    dchk_t e;
    e.is_ch = is_ch; e.slot = slot; e.val = val;
    exp_data_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_data_q.size() != 0 || exp_ack_q.size() != 0 || exp_rd_q.size() != 0) && n < 200) begin
      tick(); n++;
    end
    check("drain_data", 64'(exp_data_q.size()), 64'd0);
    check("drain_ack", 64'(exp_ack_q.size()), 64'd0);
    check("drain_rd", 64'(exp_rd_q.size()), 64'd0);
  endtask

  localparam logic [DW-1:0] ALL = {DW{1'b1}};

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] c1, c2, cs;
    int a0, n;
    rst_n = 1'b0; cen = 1'b1;
    wr_req = 1'b0; wr_sel = 1'b0; wr_op = '0; wr_ch = '0; wr_mask = '0; wr_data = '0;
    rd_req = 1'b0; rd_sel = 1'b0; rd_op = '0; rd_ch = '0;
    repeat (3) tick();

    // Reset state
    check("rst_cur_slot", 64'(cur_slot), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_ack", 64'(wr_ack), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_op_dout", 64'(op_dout), 64'd0);
    check("rst_ch_dout", 64'(ch_dout), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Counter sweep and wrap, checked every clk by the monitor
    repeat (70) tick();

    // Op write op=2,ch=5 -> slot 21
    do_write(1'b0, 2'd2, 3'd5, ALL, 42'h155, c1);
    wait_idle("idle_op_write");
    push_data(1'b0, 5'd21, 42'h155);
    drain();

    // Channel write, then masked update of the low nibble
    do_write(1'b1, 2'd0, 3'd3, ALL, 42'h3FFFFF0, c1);
    wait_idle("idle_ch_write1");
    push_data(1'b1, c1 + SW'(8), 42'h3FFFFF0);
    do_write(1'b1, 2'd0, 3'd3, 42'hF, 42'h5, c2);
    wait_idle("idle_ch_write2");
    for (int k = 1; k <= 4; k++) push_data(1'b1, c2 + SW'(8 * k), 42'h3FFFFF5);
    drain();

    // Second request while busy is dropped
    do_write(1'b0, 2'd0, 3'd2, ALL, 42'h2222, c1);
    wait_idle("idle_pre_slot2");
    do_write(1'b0, 2'd0, 3'd1, ALL, 42'h1111, c1);
    wr_req = 1'b1; wr_sel = 1'b0; wr_op = 2'd0; wr_ch = 3'd2; wr_mask = ALL; wr_data = 42'h3333;
    tick();
    wr_req = 1'b0;
    wait_idle("idle_busy_drop");
    repeat (40) tick();
    push_data(1'b0, 5'd1, 42'h1111);
    push_data(1'b0, 5'd2, 42'h2222);
    drain();

    // cen held low with the counter parked on the target slot
    do_write(1'b0, 2'd3, 3'd6, ALL, 42'h300_0000_0006, cs);
    n = 0;
    while (model_slot != 5'd30 && n < 64) begin tick(); n++; end
    check("reach_slot30", 64'(model_slot), 64'd30);
    cen = 1'b0;
    a0 = ack_cnt;
    repeat (100) tick();
    check("frozen_busy", 64'(busy), 64'd1);
    check("frozen_no_ack", 64'(ack_cnt), 64'(a0));
    cen = 1'b1;
    wait_idle("idle_after_freeze");
    push_data(1'b0, 5'd30, 42'h300_0000_0006);
    drain();

`ifdef JT51_SLOTREG_RDBK_EN
    // Readback op=1,ch=0 -> slot 8
    do_write(1'b0, 2'd1, 3'd0, ALL, 42'hABC, c1);
    wait_idle("idle_rd_pre");
    rd_req = 1'b1; rd_sel = 1'b0; rd_op = 2'd1; rd_ch = 3'd0;
    tick();
    rd_req = 1'b0;
    begin
      rchk_t r;
      r.slot = 5'd8; r.val = 42'hABC;
      exp_rd_q.push_back(r);
    end
    drain();
`else
    rd_req = 1'b1; rd_sel = 1'b0; rd_op = 2'd1; rd_ch = 3'd0;
    tick();
    rd_req = 1'b0;
    repeat (40) tick();
    check("no_rd_valid", 64'(rd_cnt), 64'd0);
    check("rd_data_zero", 64'(rd_data), 64'd0);
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
